trap_ctrl: RTL and testbench

Trap-entry/return sequencer that drives the supervisor trap CSRs (scause, sepc, stval) held by the CSR unit. It sits between the execute/commit stage and the CSR unit: it accepts one exception, interrupt or `sret` event at a time, writes the trap state into the CSR file over a valid/ready write port, then issues a one-cycle PC redirect and pipeline flush.

---
 rtl/trap_ctrl_if.sv | 45 ++++
 rtl/trap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Signal bundle between trap_ctrl and its surroundings: pipeline event inputs,
// CSR write port, and redirect/flush outputs.
interface trap_ctrl_if #(
    parameter int unsigned NUM_IRQ = 4
) ();
    // Pipeline event side
    logic               exc_valid;
    logic [4:0]         exc_code;
    logic [31:0]        exc_tval;
    logic [31:0]        pc;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               sie;
    logic               sret_valid;
    logic [31:0]        stvec;
    logic [31:0]        sepc_q;

    // CSR write port
    logic               csr_wr_valid;
    logic [11:0]        csr_wr_addr;
    logic [31:0]        csr_wr_data;
    logic               csr_wr_ready;

    // Control outputs to the pipeline
    logic               busy;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               flush;
    logic               sie_clear;
    logic               sie_restore;

    // The sequencer's own view: it drives the CSR write port and redirect.
    modport master (
        input  exc_valid, exc_code, exc_tval, pc, irq_pending, sie, sret_valid,
        input  stvec, sepc_q, csr_wr_ready,
        output csr_wr_valid, csr_wr_addr, csr_wr_data,
        output busy, redirect_valid, redirect_pc, flush, sie_clear, sie_restore
    );

    modport slave (
        output exc_valid, exc_code, exc_tval, pc, irq_pending, sie, sret_valid,
        output stvec, sepc_q, csr_wr_ready,
        input  csr_wr_valid, csr_wr_addr, csr_wr_data,
        input  busy, redirect_valid, redirect_pc, flush, sie_clear, sie_restore
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap-entry/return sequencer: writes scause/sepc/stval over a valid/ready
// port, then issues a one-cycle PC redirect with pipeline flush.
module trap_ctrl #(
    parameter int unsigned NUM_IRQ = 4
) (
    input logic          clk,
    input logic          rst_n,
    trap_ctrl_if.master  bus
);

    localparam logic [11:0] AddrScause = 12'h142;
    localparam logic [11:0] AddrSepc   = 12'h141;
    localparam logic [11:0] AddrStval  = 12'h143;

    typedef enum logic [2:0] {
        StIdle,
        StWScause,
        StWSepc,
        StWStval,
        StRedirect
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic        is_irq_q, is_irq_d;
    logic        is_sret_q, is_sret_d;
    logic [3:0]  irq_idx_q, irq_idx_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        csr_wr_valid_q, csr_wr_valid_d;
    logic [11:0] csr_wr_addr_q, csr_wr_addr_d;
    logic [31:0] csr_wr_data_q, csr_wr_data_d;
    logic        busy_q, busy_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        sie_clear_q, sie_clear_d;
    logic        sie_restore_q, sie_restore_d;

    logic        irq_any;
    logic [3:0]  irq_sel;
    logic        wr_done;
    logic [31:0] vec_base;
    logic [31:0] vec_offs;

    // Lowest-numbered pending line wins.
    always_comb begin
        irq_sel = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (bus.irq_pending[i]) begin
                irq_sel = 4'(i);
            end
        end
    end

    assign irq_any  = |bus.irq_pending;
    assign wr_done  = csr_wr_valid_q && bus.csr_wr_ready;
    assign vec_base = bus.stvec & 32'hFFFF_FFFC;
    assign vec_offs = (bus.stvec[1:0] == 2'b01 && is_irq_q) ? {26'b0, irq_idx_q, 2'b00} : 32'h0;

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        tval_d        = tval_q;
        is_irq_d      = is_irq_q;
        is_sret_d     = is_sret_q;
        irq_idx_d     = irq_idx_q;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            StIdle: begin
                if (bus.exc_valid) begin
                    cause_d   = {27'b0, bus.exc_code};
                    epc_d     = bus.pc & 32'hFFFF_FFFC;
                    tval_d    = bus.exc_tval;
                    is_irq_d  = 1'b0;
                    is_sret_d = 1'b0;
                    irq_idx_d = '0;
                    state_d   = StWScause;
                end else if (bus.sie && irq_any) begin
                    cause_d   = 32'h8000_0000 | {28'b0, irq_sel};
                    epc_d     = bus.pc & 32'hFFFF_FFFC;
                    tval_d    = '0;
                    is_irq_d  = 1'b1;
                    is_sret_d = 1'b0;
                    irq_idx_d = irq_sel;
                    state_d   = StWScause;
                end else if (bus.sret_valid) begin
                    is_sret_d     = 1'b1;
                    redirect_pc_d = bus.sepc_q & 32'hFFFF_FFFC;
                    state_d       = StRedirect;
                end
            end
            StWScause: if (wr_done) state_d = StWSepc;
            StWSepc:   if (wr_done) state_d = StWStval;
            StWStval: begin
                // stvec is consumed only here, on the last write handshake.
                if (wr_done) begin
                    redirect_pc_d = vec_base + vec_offs;
                    state_d       = StRedirect;
                end
            end
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs are derived from the next state so they can be registered.
    always_comb begin
        csr_wr_valid_d = 1'b0;
        csr_wr_addr_d  = '0;
        csr_wr_data_d  = '0;
        case (state_d)
            StWScause: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = AddrScause;
                csr_wr_data_d  = cause_d;
            end
            StWSepc: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = AddrSepc;
                csr_wr_data_d  = epc_d;
            end
            StWStval: begin
                csr_wr_valid_d = 1'b1;
                csr_wr_addr_d  = AddrStval;
                csr_wr_data_d  = tval_d;
            end
            default: begin
                csr_wr_valid_d = 1'b0;
            end
        endcase
        busy_d           = (state_d != StIdle);
        redirect_valid_d = (state_d == StRedirect);
        sie_clear_d      = (state_d == StRedirect) && !is_sret_d;
        sie_restore_d    = (state_d == StRedirect) && is_sret_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cause_q          <= '0;
            epc_q            <= '0;
            tval_q           <= '0;
            is_irq_q         <= 1'b0;
            is_sret_q        <= 1'b0;
            irq_idx_q        <= '0;
            redirect_pc_q    <= '0;
            csr_wr_valid_q   <= 1'b0;
            csr_wr_addr_q    <= '0;
            csr_wr_data_q    <= '0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            sie_clear_q      <= 1'b0;
            sie_restore_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            epc_q            <= epc_d;
            tval_q           <= tval_d;
            is_irq_q         <= is_irq_d;
            is_sret_q        <= is_sret_d;
            irq_idx_q        <= irq_idx_d;
            redirect_pc_q    <= redirect_pc_d;
            csr_wr_valid_q   <= csr_wr_valid_d;
            csr_wr_addr_q    <= csr_wr_addr_d;
            csr_wr_data_q    <= csr_wr_data_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            sie_clear_q      <= sie_clear_d;
            sie_restore_q    <= sie_restore_d;
        end
    end

    assign bus.csr_wr_valid   = csr_wr_valid_q;
    assign bus.csr_wr_addr    = csr_wr_addr_q;
    assign bus.csr_wr_data    = csr_wr_data_q;
    assign bus.busy           = busy_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = redirect_valid_q;
    assign bus.sie_clear      = sie_clear_q;
    assign bus.sie_restore    = sie_restore_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios followed by randomized events,
// each checked against an arithmetic model of trap/sret behaviour.
module tb_trap_ctrl;

    localparam int unsigned NIrq = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    trap_ctrl_if #(.NUM_IRQ(NIrq)) bus ();

    trap_ctrl #(.NUM_IRQ(NIrq)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {14'b0, bus.csr_wr_valid, bus.csr_wr_addr, bus.csr_wr_data, bus.busy,
                bus.redirect_valid, bus.redirect_pc, bus.flush, bus.sie_clear, bus.sie_restore};
    endfunction

    task automatic clear_events();
        bus.exc_valid   = 1'b0;
        bus.exc_code    = '0;
        bus.exc_tval    = '0;
        bus.pc          = '0;
        bus.irq_pending = '0;
        bus.sie         = 1'b0;
        bus.sret_valid  = 1'b0;
        bus.sepc_q      = '0;
    endtask

    // Garbage on event inputs while busy must have no effect; stvec is left alone.
    task automatic scramble();
        bus.exc_valid   = 1'($urandom);
        bus.exc_code    = 5'($urandom);
        bus.exc_tval    = $urandom;
        bus.pc          = $urandom;
        bus.irq_pending = NIrq'($urandom);
        bus.sie         = 1'($urandom);
        bus.sret_valid  = 1'($urandom);
        bus.sepc_q      = $urandom;
    endtask

    // Reference: kind 0 = nothing, 1 = trap, 2 = sret.
    function automatic void model(output int kind, output logic [31:0] cause,
                                  output logic [31:0] epc, output logic [31:0] tval,
                                  output logic [31:0] target);
        int idx;
        bit found;
        kind = 0; cause = 0; epc = 0; tval = 0; target = 0;
        idx = 0; found = 0;
        for (int i = 0; i < int'(NIrq); i++) begin
            if (!found && bus.irq_pending[i]) begin
                idx = i;
                found = 1;
            end
        end
        if (bus.exc_valid) begin
            kind   = 1;
            cause  = 32'(bus.exc_code);
            epc    = bus.pc - (bus.pc % 4);
            tval   = bus.exc_tval;
            target = bus.stvec - (bus.stvec % 4);
        end else if (bus.sie && found) begin
            kind   = 1;
            cause  = 32'h8000_0000 + 32'(idx);
            epc    = bus.pc - (bus.pc % 4);
            tval   = 0;
            target = bus.stvec - (bus.stvec % 4);
            if (bus.stvec % 4 == 1) target = target + 32'(4 * idx);
        end else if (bus.sret_valid) begin
            kind   = 2;
            target = bus.sepc_q - (bus.sepc_q % 4);
        end
    endfunction

    // Event inputs are already set; edge 0 is the next posedge.
    // rmode: 0 = ready high, 1 = random ready, 2 = ready low 3 cycles on sepc write.
    task automatic run_event(input string tag, input int rmode);
        int          kind;
        logic [31:0] cause, epc, tval, tgt;
        logic [11:0] ea[3];
        logic [31:0] ed[3];
        int          widx, stalls, cyc, lowcnt, exp_cyc;
        bit          done;
        model(kind, cause, epc, tval, tgt);
        ea[0] = 12'h142; ea[1] = 12'h141; ea[2] = 12'h143;
        ed[0] = cause;   ed[1] = epc;     ed[2] = tval;
        widx = 0; stalls = 0; cyc = 0; lowcnt = 0; done = 0;
        if (kind == 0) begin
            repeat (3) begin
                @(negedge clk);
                check({tag, "_idle_busy"}, 96'(bus.busy), 96'd0);
                check({tag, "_idle_wr"}, 96'(bus.csr_wr_valid), 96'd0);
                check({tag, "_idle_redir"}, 96'(bus.redirect_valid), 96'd0);
            end
            clear_events();
            return;
        end
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            check({tag, "_busy"}, 96'(bus.busy), 96'd1);
            if (bus.csr_wr_valid) begin
                if (kind == 2 || widx > 2) begin
                    check({tag, "_spurious_wr"}, 96'(bus.csr_wr_valid), 96'd0);
                end else begin
                    check({tag, "_wr_addr"}, 96'(bus.csr_wr_addr), 96'(ea[widx]));
                    check({tag, "_wr_data"}, 96'(bus.csr_wr_data), 96'(ed[widx]));
                end
            end
            if (rmode == 1) bus.csr_wr_ready = ($urandom_range(0, 2) != 0);
            else if (rmode == 2 && bus.csr_wr_valid && bus.csr_wr_addr == 12'h141 && lowcnt < 3) begin
                bus.csr_wr_ready = 1'b0;
                lowcnt++;
            end else bus.csr_wr_ready = 1'b1;
            if (bus.csr_wr_valid) begin
                if (bus.csr_wr_ready) widx++;
                else stalls++;
            end
            if (bus.redirect_valid) begin
                done = 1;
                exp_cyc = (kind == 1) ? 4 + stalls : 1;
                check({tag, "_redir_cycle"}, 96'(cyc), 96'(exp_cyc));
                check({tag, "_writes_done"}, 96'(widx), 96'((kind == 1) ? 3 : 0));
                check({tag, "_redir_pc"}, 96'(bus.redirect_pc), 96'(tgt));
                check({tag, "_flush"}, 96'(bus.flush), 96'd1);
                check({tag, "_sie_clear"}, 96'(bus.sie_clear), 96'(kind == 1));
                check({tag, "_sie_restore"}, 96'(bus.sie_restore), 96'(kind == 2));
                clear_events();
            end else begin
                scramble();
            end
        end
        if (!done) check({tag, "_timeout"}, 96'd0, 96'd1);
        clear_events();
        bus.csr_wr_ready = 1'b1;
        @(negedge clk);
        check({tag, "_back_idle"}, 96'({bus.busy, bus.redirect_valid, bus.flush}), 96'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_events();
        bus.stvec        = '0;
        bus.csr_wr_ready = 1'b1;
        rst_n            = 1'b0;

        // Reset with every input active.
        bus.exc_valid   = 1'b1;
        bus.exc_code    = 5'h1F;
        bus.exc_tval    = 32'hFFFF_FFFF;
        bus.pc          = 32'hFFFF_FFFF;
        bus.irq_pending = '1;
        bus.sie         = 1'b1;
        bus.sret_valid  = 1'b1;
        bus.sepc_q      = 32'hFFFF_FFFF;
        bus.stvec       = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), 96'd0);
        clear_events();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 96'd0);

        // Exception, ready high.
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd2;
        bus.pc        = 32'h0000_1006;
        bus.exc_tval  = 32'hDEAD_BEEF;
        bus.stvec     = 32'h8000_0000;
        run_event("exc", 0);

        // Vectored interrupt.
        bus.irq_pending = 4'b1010;
        bus.sie         = 1'b1;
        bus.pc          = 32'h0000_4000;
        bus.stvec       = 32'h8000_0101;
        run_event("virq", 0);

        // All three events at once: exception wins.
        bus.exc_valid   = 1'b1;
        bus.exc_code    = 5'd13;
        bus.exc_tval    = 32'h1234_5678;
        bus.pc          = 32'h0000_0802;
        bus.irq_pending = 4'b0001;
        bus.sie         = 1'b1;
        bus.sret_valid  = 1'b1;
        bus.sepc_q      = 32'h0000_3000;
        run_event("prio", 0);

        // Masked interrupt: no activity.
        bus.irq_pending = 4'b0100;
        bus.sie         = 1'b0;
        run_event("masked", 0);

        // Back-pressure on the sepc write.
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd7;
        bus.exc_tval  = 32'h0BAD_F00D;
        bus.pc        = 32'h0000_2221;
        bus.stvec     = 32'h0001_0001;
        run_event("bp", 2);

        // sret.
        bus.sret_valid = 1'b1;
        bus.sepc_q     = 32'h0000_2003;
        run_event("sret", 0);

        // Reset in the middle of the scause write.
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd5;
        bus.pc        = 32'h0000_0100;
        @(negedge clk);
        check("midrst_wr_valid", 96'(bus.csr_wr_valid), 96'd1);
        clear_events();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outs", all_outs(), 96'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", all_outs(), 96'd0);

        // Randomized events with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            bus.exc_valid   = ($urandom_range(0, 2) == 0);
            bus.exc_code    = 5'($urandom);
            bus.exc_tval    = $urandom;
            bus.pc          = $urandom;
            bus.irq_pending = NIrq'($urandom);
            bus.sie         = 1'($urandom);
            bus.sret_valid  = 1'($urandom);
            bus.sepc_q      = $urandom;
            bus.stvec       = $urandom;
            if ($urandom_range(0, 1) == 1) bus.stvec[1:0] = 2'b01;
            run_event("rand", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
